// File: rtl/uob_arbiter.sv
// rtl/uob_arbiter.sv - round-robin read scheduler muxing UOB packets onto one output bus
module uob_arbiter #(
    parameter int N_UNITS     = 8,
    parameter int OUT_WIDTH   = 8,
    parameter int OUT_N_WORDS = 24,
    parameter int UNIT_ID_MSB = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_UNITS-1:0]             uob_empty,
    output logic [N_UNITS-1:0]             uob_rd_en,
    input  logic [N_UNITS*OUT_WIDTH-1:0]   uob_dout,
    input  logic                           out_ready,
    output logic [OUT_WIDTH-1:0]           dout,
    output logic                           wr_en,
    output logic [UNIT_ID_MSB:0]           unit_id,
    output logic                           busy
);

    // Counter only has to reach OUT_N_WORDS-1; it is cleared on every header.
    localparam int                    CNT_W     = (OUT_N_WORDS > 1) ? $clog2(OUT_N_WORDS) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(OUT_N_WORDS - 1);
    // One extra bit so pointer+offset can exceed N_UNITS before the modulo fold.
    localparam int                    IDX_W     = UNIT_ID_MSB + 2;
    localparam logic [IDX_W-1:0]      N_EXT     = IDX_W'(N_UNITS);
    localparam logic [UNIT_ID_MSB:0]  LAST_UNIT = (UNIT_ID_MSB + 1)'(N_UNITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HDR,
        XFER
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [UNIT_ID_MSB:0]   ptr;
    logic [UNIT_ID_MSB:0]   sel;
    logic [UNIT_ID_MSB:0]   winner;
    logic                   any_req;
    logic [CNT_W-1:0]       cnt;
    logic [OUT_WIDTH-1:0]   unit_word [N_UNITS];

    for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_split
        assign unit_word[gi] = uob_dout[gi*OUT_WIDTH +: OUT_WIDTH];
    end

    // First non-empty unit at or after the priority pointer, wrapping modulo N_UNITS.
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx     = '0;
        any_req = 1'b0;
        winner  = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            idx = {1'b0, ptr} + IDX_W'(k);
            if (idx >= N_EXT) begin
                idx = idx - N_EXT;
            end
            if (!any_req && !uob_empty[idx[UNIT_ID_MSB:0]]) begin
                any_req = 1'b1;
                winner  = idx[UNIT_ID_MSB:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the one-cycle read strobe; grants only when a whole packet fits downstream.
    always_comb begin
        state_nxt = state;
        uob_rd_en = '0;
        case (state)
            IDLE: begin
                if (out_ready && any_req) begin
                    uob_rd_en[winner] = 1'b1;
                    state_nxt         = WAIT_HDR;
                end
            end
            WAIT_HDR: begin
                state_nxt = XFER;
            end
            XFER: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output register, word counter, selected unit and priority pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout    <= '0;
            wr_en   <= 1'b0;
            unit_id <= '0;
            busy    <= 1'b0;
            ptr     <= '0;
            sel     <= '0;
            cnt     <= '0;
        end else begin
            busy <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    dout  <= '0;
                    wr_en <= 1'b0;
                    if (out_ready && any_req) begin
                        sel <= winner;
                    end
                end
                WAIT_HDR: begin
                    dout    <= unit_word[sel];
                    wr_en   <= 1'b1;
                    unit_id <= sel;
                    cnt     <= '0;
                end
                XFER: begin
                    dout  <= unit_word[sel];
                    wr_en <= 1'b1;
                    if (cnt == CNT_LAST) begin
                        // Served unit drops to lowest priority for the next round.
                        ptr <= (sel == LAST_UNIT) ? '0 : sel + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    dout  <= '0;
                    wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uob_arbiter.sv
// tb/tb_uob_arbiter.sv - randomized scoreboard bench for uob_arbiter
module tb_uob_arbiter;

    localparam int NU  = 8;
    localparam int W   = 8;
    localparam int NW  = 24;
    localparam int MSB = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NU-1:0]     uob_empty;
    logic [NU-1:0]     uob_rd_en;
    logic [NU*W-1:0]   uob_dout;
    logic              out_ready;
    logic [W-1:0]      dout;
    logic              wr_en;
    logic [MSB:0]      unit_id;
    logic              busy;

    uob_arbiter #(
        .N_UNITS     (NU),
        .OUT_WIDTH   (W),
        .OUT_N_WORDS (NW),
        .UNIT_ID_MSB (MSB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uob_empty (uob_empty),
        .uob_rd_en (uob_rd_en),
        .uob_dout  (uob_dout),
        .out_ready (out_ready),
        .dout      (dout),
        .wr_en     (wr_en),
        .unit_id   (unit_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // UOB environment
    int          pending [NU];
    int          pos     [NU];
    int          spkt    [NU];
    int          env_pkt [NU];
    logic [NU-1:0] last_rd;
    bit          ready_drv;

    // Reference model
    int          m_ptr;
    int          m_next_idle;
    int          m_busy_lo;
    int          m_busy_hi;
    int          m_pkt [NU];
    bit          r_wr   [64];
    logic [7:0]  r_dout [64];
    int          r_uid  [64];

    int          obs_grants [$];
    int          obs_gcyc   [$];
    int          wr_count;

    function automatic logic [7:0] word_of(int u, int p, int w);
        return 8'((u * 53 + p * 29 + w * 7 + 3) % 255);
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_order(string tag, int exp_q[$]);
        check({tag, "_count"}, obs_grants.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_grants.size(); i++) begin
            check($sformatf("%s_%0d", tag, i), obs_grants[i], exp_q[i]);
        end
    endtask

    task automatic clear_obs();
        obs_grants.delete();
        obs_gcyc.delete();
        wr_count = 0;
    endtask

    task automatic drive_env();
        for (int i = 0; i < NU; i++) begin
            if (pos[i] >= 0) begin
                pos[i]++;
                if (pos[i] > NW) pos[i] = -1;
            end
        end
        for (int i = 0; i < NU; i++) begin
            if (last_rd[i]) begin
                if (pending[i] > 0) pending[i]--;
                pos[i]  = 0;
                spkt[i] = env_pkt[i];
                env_pkt[i]++;
            end
        end
        for (int i = 0; i < NU; i++) begin
            uob_empty[i] = (pending[i] == 0);
            if (pos[i] < 0)       uob_dout[i*W +: W] = 8'($urandom);
            else if (pos[i] == 0) uob_dout[i*W +: W] = 8'hFF;
            else                  uob_dout[i*W +: W] = word_of(i, spkt[i], pos[i] - 1);
        end
        out_ready = ready_drv;
    endtask

    task automatic model_and_check();
        int            slot;
        logic [NU-1:0] exp_rd;
        slot   = cyc % 64;
        exp_rd = '0;
        if (cyc >= m_next_idle && out_ready && (uob_empty != '1)) begin
            int wn;
            wn = -1;
            for (int k = 0; k < NU; k++) begin
                int u;
                u = (m_ptr + k) % NU;
                if (wn < 0 && !uob_empty[u]) wn = u;
            end
            exp_rd[wn] = 1'b1;
            for (int k = 0; k <= NW; k++) begin
                int s;
                s         = (cyc + 2 + k) % 64;
                r_wr[s]   = 1'b1;
                r_dout[s] = (k == 0) ? 8'hFF : word_of(wn, m_pkt[wn], k - 1);
                r_uid[s]  = wn;
            end
            m_pkt[wn]++;
            m_ptr       = (wn + 1) % NU;
            m_next_idle = cyc + NW + 2;
            m_busy_lo   = cyc + 1;
            m_busy_hi   = cyc + 1 + NW;
        end
        check("rd_en", uob_rd_en, exp_rd);
        check("wr_en", wr_en, r_wr[slot]);
        check("dout", dout, r_wr[slot] ? r_dout[slot] : 8'h00);
        if (r_wr[slot]) check("unit_id", unit_id, r_uid[slot]);
        check("busy", busy, (cyc >= m_busy_lo && cyc <= m_busy_hi));
        r_wr[slot] = 1'b0;
        last_rd    = uob_rd_en;
        for (int k = 0; k < NU; k++) begin
            if (uob_rd_en[k]) begin
                obs_grants.push_back(k);
                obs_gcyc.push_back(cyc);
            end
        end
        if (wr_en) wr_count++;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        drive_env();
        #1;
        model_and_check();
    endtask

    task automatic reset_tb_state();
        for (int i = 0; i < NU; i++) begin
            pending[i] = 0;
            pos[i]     = -1;
        end
        for (int s = 0; s < 64; s++) r_wr[s] = 1'b0;
        last_rd     = '0;
        m_ptr       = 0;
        m_next_idle = 0;
        m_busy_lo   = 1;
        m_busy_hi   = 0;
        drive_env();
    endtask

    task automatic do_reset(input bit check_async);
        #3;
        rst = 1'b1;
        #1;
        if (check_async) begin
            check("rst_async_wr_en", wr_en, 1'b0);
            check("rst_async_busy", busy, 1'b0);
        end
        reset_tb_state();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        int q[$];
        int guard;
        rst       = 1'b1;
        ready_drv = 1'b0;
        for (int i = 0; i < NU; i++) begin
            spkt[i]    = 0;
            env_pkt[i] = 0;
            m_pkt[i]   = 0;
        end
        reset_tb_state();
        repeat (3) @(posedge clk);
        #2;
        check("reset_rd_en", uob_rd_en, '0);
        check("reset_dout", dout, '0);
        check("reset_wr_en", wr_en, 1'b0);
        check("reset_unit_id", unit_id, '0);
        check("reset_busy", busy, 1'b0);
        #3;
        rst = 1'b0;

        // Single request from unit 3
        clear_obs();
        pending[3] = 1;
        ready_drv  = 1'b1;
        repeat (40) step();
        q = '{3};
        check_order("single", q);
        check("single_wr_count", wr_count, 25);
        check("single_busy_after", busy, 1'b0);

        // Round-robin fairness among units 0, 2, 7
        do_reset(1'b0);
        clear_obs();
        pending[0] = 2;
        pending[2] = 2;
        pending[7] = 2;
        repeat (6 * 26 + 10) step();
        q = '{0, 2, 7, 0, 2, 7};
        check_order("fair", q);
        check("fair_wr_count", wr_count, 6 * 25);

        // Backpressure holds off grants, release grants in the same cycle
        do_reset(1'b0);
        clear_obs();
        ready_drv  = 1'b0;
        pending[1] = 1;
        pending[4] = 1;
        pending[6] = 1;
        repeat (50) step();
        check("bp_no_grant", obs_grants.size(), 0);
        ready_drv = 1'b1;
        step();
        check("bp_same_cycle", obs_grants.size(), 1);
        repeat (90) step();
        q = '{1, 4, 6};
        check_order("bp", q);

        // Back-to-back packets from units 1 and 5
        do_reset(1'b0);
        clear_obs();
        pending[1] = 1;
        pending[5] = 1;
        repeat (70) step();
        q = '{1, 5};
        check_order("b2b", q);
        if (obs_gcyc.size() == 2) check("b2b_spacing", obs_gcyc[1] - obs_gcyc[0], NW + 2);

        // Reset in the middle of a packet
        do_reset(1'b0);
        clear_obs();
        pending[2] = 1;
        guard = 0;
        while (obs_grants.size() == 0 && guard < 50) begin
            step();
            guard++;
        end
        check("mid_grant_seen", obs_grants.size() > 0, 1'b1);
        repeat (12) step();
        check("mid_wr_before_rst", wr_en, 1'b1);
        do_reset(1'b1);
        clear_obs();
        pending[4] = 1;
        repeat (40) step();
        q = '{4};
        check_order("mid_after", q);
        check("mid_after_wr_count", wr_count, 25);

        // Pointer wrap from unit 7 back to unit 0
        do_reset(1'b0);
        clear_obs();
        pending[6] = 1;
        repeat (30) step();
        pending[7] = 1;
        repeat (30) step();
        pending[0] = 1;
        pending[7] = 1;
        repeat (60) step();
        q = '{6, 7, 0, 7};
        check_order("wrap", q);

        // Random traffic against the scoreboard
        do_reset(1'b0);
        clear_obs();
        repeat (1500) begin
            if ($urandom_range(0, 7) == 0) begin
                int u;
                u = int'($urandom_range(0, NU - 1));
                if (pending[u] < 3) pending[u]++;
            end
            ready_drv = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
